// File: rtl/mem_burst_reader_pkg.sv
// Shared types and sizing for the burst reader.
// Holds the RAM geometry, FIFO depth, FSM states and the stream entry.
package mem_burst_pkg;

  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } entry_t;

endpackage

// File: rtl/mem_burst_reader_if.sv
// Command, RAM read port and output stream bundle.
// The slave modport is the reader's view; master is the environment's view.
interface mem_burst_reader_if;
  import mem_burst_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len,
    input  mem_rdata, out_ready,
    output cmd_ready, mem_rd_en, mem_addr,
    output out_valid, out_data, out_last, busy
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_len,
    output mem_rdata, out_ready,
    input  cmd_ready, mem_rd_en, mem_addr,
    input  out_valid, out_data, out_last, busy
  );

endinterface

// File: rtl/mem_burst_reader_fifo.sv
// Small synchronous FIFO of stream entries with count and flush.
// A push into a full FIFO is accepted only when a pop happens alongside.
module mem_burst_fifo
  import mem_burst_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  entry_t           din,
  input  logic             pop,
  output entry_t           head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic             clr;

  assign clr     = rst || flush;
  assign do_pop  = pop && (count != '0);
  assign do_push = push &&
                   (count != CNT_W'(FIFO_DEPTH) || do_pop);

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/mem_burst_reader.sv
// Burst read initiator: one RAM read per cycle, streamed out valid/ready.
// Optional abort input enabled by MEM_BURST_READER_ABORT_EN.
module mem_burst_reader
  import mem_burst_pkg::*;
(
  input logic clk,
  input logic rst,
`ifdef MEM_BURST_READER_ABORT_EN
  input logic abort,
`endif
  mem_burst_reader_if.slave bus
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   rem;
  logic              inflight;
  logic              inflight_last;
  logic [CNT_W-1:0]  fifo_count;
  entry_t            head;
  entry_t            din;
  logic              kill;
  logic              credit;
  logic              issue;
  logic              pop;
  logic              cmd_fire;
  logic              final_issue;

`ifdef MEM_BURST_READER_ABORT_EN
  assign kill = abort && (state != IDLE);
`else
  assign kill = 1'b0;
`endif

  // Reserve a FIFO slot for the read still in the RAM pipeline.
  assign credit = ((CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight))
                  < (CNT_W+1)'(FIFO_DEPTH);

  assign cmd_fire    = bus.cmd_valid && bus.cmd_ready;
  assign issue       = (state == READ) && credit && !kill && !rst;
  assign final_issue = issue && (rem == (ADDR_W+1)'(1));
  assign pop         = bus.out_valid && bus.out_ready && !kill;

  assign bus.cmd_ready = (state == IDLE) && !rst;
  assign bus.busy      = (state != IDLE);
  assign bus.mem_rd_en = issue;
  assign bus.mem_addr  = addr;
  assign bus.out_valid = (fifo_count != '0);
  assign bus.out_data  = bus.out_valid ? head.data : '0;
  assign bus.out_last  = bus.out_valid && head.last;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (cmd_fire) state_nxt = READ;
      READ:  if (final_issue) state_nxt = DRAIN;
      DRAIN: if (!inflight &&
                 (fifo_count == '0 ||
                  (fifo_count == CNT_W'(1) && pop)))
               state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr          <= '0;
      rem           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= final_issue;
      if (cmd_fire) begin
        addr <= bus.cmd_addr;
        rem  <= {1'b0, bus.cmd_len} + (ADDR_W+1)'(1);
      end else if (issue) begin
        addr <= addr + ADDR_W'(1);
        rem  <= rem - (ADDR_W+1)'(1);
      end
    end
  end

  assign din = '{data: bus.mem_rdata, last: inflight_last};

  mem_burst_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (kill),
    .push  (inflight && !kill),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_mem_burst_reader.sv
// Randomized bench for mem_burst_reader with a queue-based reference.
// Define MEM_BURST_READER_ABORT_EN to also exercise abort.
module tb_mem_burst_reader;
  import mem_burst_pkg::*;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              l;
  } exp_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic abort = 1'b0;

  mem_burst_reader_if bus ();

  mem_burst_reader dut (
    .clk   (clk),
`ifdef MEM_BURST_READER_ABORT_EN
    .abort (abort),
`endif
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  always @(posedge clk)
    if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr];

  int n_vec = 0;
  int n_err = 0;
  int outstanding = 0;
  int hs_total = 0;
  int last_total = 0;
  int rdy_mode = 0;

  exp_t              exp_q[$];
  logic [ADDR_W-1:0] ea_q[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // 0: always ready, 1: random, 2: stalled
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom % 2);
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Reference model: expected address and word streams per accepted command.
  always @(negedge clk) begin
    if (rst || (abort && bus.busy)) begin
      exp_q.delete();
      ea_q.delete();
      outstanding = 0;
    end else begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
        else begin
          chk("data", bus.out_data, exp_q[0].d);
          chk("last", bus.out_last, exp_q[0].l);
        end
        if (bus.out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          hs_total++;
          if (bus.out_last) last_total++;
          outstanding--;
        end
      end
      if (bus.mem_rd_en) begin
        if (ea_q.size() == 0) chk("spurious_rd", 1, 0);
        else chk("addr", bus.mem_addr, ea_q.pop_front());
        outstanding++;
        chk("credit", outstanding <= FIFO_DEPTH, 1);
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        for (int i = 0; i <= int'(bus.cmd_len); i++) begin
          logic [ADDR_W-1:0] a;
          a = bus.cmd_addr + ADDR_W'(i);
          ea_q.push_back(a);
          exp_q.push_back('{ram[a], i == int'(bus.cmd_len)});
        end
      end
    end
  end

  task automatic send(input logic [ADDR_W-1:0] a,
                      input logic [ADDR_W-1:0] l);
    int budget;
    budget = 100;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    @(negedge clk);
    while (!bus.cmd_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("cmd_ready_wait", bus.cmd_ready, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    @(negedge clk);
    while (bus.busy && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("idle", bus.busy, 0);
    chk("drained", exp_q.size(), 0);
    chk("cmd_ready_idle", bus.cmd_ready, 1);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_valid"}, bus.out_valid, 0);
    chk({pfx, "_last"}, bus.out_last, 0);
    chk({pfx, "_data"}, bus.out_data, 0);
    chk({pfx, "_rd_en"}, bus.mem_rd_en, 0);
    chk({pfx, "_mem_addr"}, bus.mem_addr, 0);
    chk({pfx, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    logic [ADDR_W-1:0] start;
    int base;
    int lbase;
    int b;

    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b1;
    foreach (ram[i]) ram[i] = $urandom;

    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", bus.cmd_ready, 1);

    // Directed cycle-accurate burst
    send(15'h0010, 15'd3);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("t%0d_rd", k), bus.mem_rd_en, k <= 4);
      if (k <= 4)
        chk($sformatf("t%0d_addr", k), bus.mem_addr, 16 + k - 1);
      chk($sformatf("t%0d_valid", k), bus.out_valid, k >= 3 && k <= 6);
      chk($sformatf("t%0d_olast", k), bus.out_last, k == 6);
      chk($sformatf("t%0d_busy", k), bus.busy, k <= 6);
      chk($sformatf("t%0d_cready", k), bus.cmd_ready, k == 7);
    end

    // Address wrap
    send(15'h7FFE, 15'd3);
    wait_idle(50);

    // Backpressure
    rdy_mode = 1;
    send(ADDR_W'($urandom), 15'd15);
    wait_idle(500);
    for (int n = 0; n < 6; n++) begin
      send(ADDR_W'($urandom), ADDR_W'($urandom_range(0, 40)));
      wait_idle(1000);
    end
    rdy_mode = 0;

    // Maximum length
    start = ADDR_W'($urandom);
    base  = hs_total;
    lbase = last_total;
    send(start, 15'h7FFF);
    wait_idle(40000);
    chk("max_hs", hs_total - base, 32768);
    chk("max_last", last_total - lbase, 1);
    chk("max_home", bus.mem_addr, start);

    // Reset mid-burst
    send(ADDR_W'($urandom), 15'd20);
    base = hs_total;
    b = 100;
    while (hs_total - base < 5 && b > 0) begin
      @(negedge clk);
      b--;
    end
    chk("mid_hs5", hs_total - base >= 5, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");
    chk("midrst_cmd_ready", bus.cmd_ready, 1);
    base  = hs_total;
    lbase = last_total;
    send(ADDR_W'($urandom), 15'd0);
    wait_idle(20);
    chk("single_hs", hs_total - base, 1);
    chk("single_last", last_total - lbase, 1);

`ifdef MEM_BURST_READER_ABORT_EN
    rdy_mode = 2;
    lbase = last_total;
    send(ADDR_W'($urandom), 15'd10);
    repeat (6) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_last", bus.out_last, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_cready", bus.cmd_ready, 1);
    rdy_mode = 0;
    send(ADDR_W'($urandom), 15'd2);
    wait_idle(30);
    chk("abort_after_last", last_total - lbase, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
